// File: rtl/parallel_to_serial.sv
// parallel_to_serial
//   Converts width-bit parallel words into a one-bit serial stream with
//   valid/ready handshakes on both sides. A one-entry holding buffer accepts
//   the next word while the current one shifts out, so back-to-back words
//   stream without an idle cycle.
//
//   Optional feature macro: PARALLEL_TO_SERIAL_PARITY_EN
//     defined   : each frame is width data bits followed by one even-parity
//                 bit (^word); serial_last marks the parity bit.
//     undefined : each frame is width data bits; serial_last marks the final
//                 data bit.
//
// Parameters
//   width      data bits per word (>= 2)
//   msb_first  0: bit 0 sent first, 1: bit width-1 sent first
//
// Ports
//   clk             in   clock, all state on posedge
//   rst             in   asynchronous active-low reset
//   parallel_valid  in   upstream word valid
//   parallel_ready  out  block can accept a word (registered, = !hold_full)
//   parallel_data   in   upstream word
//   serial_valid    out  serial_data holds a valid bit
//   serial_ready    in   downstream accepts the current bit
//   serial_data     out  current serial bit
//   serial_last     out  current bit is the final bit of the frame
module parallel_to_serial #(
  parameter int unsigned width     = 8,
  parameter bit          msb_first = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  input  logic [width-1:0] parallel_data,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             serial_data,
  output logic             serial_last
);

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  localparam int unsigned FRAME_LEN = width + 1;
`else
  localparam int unsigned FRAME_LEN = width;
`endif
  localparam int unsigned   CW       = $clog2(width + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [width-1:0] shifter_q;
  logic [width-1:0] hold_q;
  logic             hold_full_q;
  logic [CW-1:0]    cnt_q;

  logic word_acc;
  logic bit_xfer;
  logic last_xfer;
  logic load_word;   // parallel_data -> shifter
  logic load_hold;   // hold -> shifter
  logic to_hold;     // parallel_data -> hold
  logic head_bit;

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  logic par_q;
`endif

  assign head_bit = msb_first ? shifter_q[width-1] : shifter_q[0];

  always_comb begin
    state_d        = state_q;
    load_word      = 1'b0;
    load_hold      = 1'b0;
    to_hold        = 1'b0;
    parallel_ready = !hold_full_q;
    serial_valid   = (state_q == SHIFT);
    serial_last    = 1'b0;
    serial_data    = 1'b0;

    word_acc  = parallel_valid && parallel_ready;
    bit_xfer  = serial_valid && serial_ready;
    last_xfer = bit_xfer && (cnt_q == LAST_IDX);

    if (serial_valid) begin
      serial_last = (cnt_q == LAST_IDX);
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
      serial_data = (cnt_q < CW'(width)) ? head_bit : par_q;
`else
      serial_data = head_bit;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (word_acc) begin
          load_word = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // A word accepted on the last-bit cycle bypasses the hold buffer;
        // parallel_ready is low whenever hold is full, so the two load
        // sources never collide.
        if (last_xfer) begin
          if (hold_full_q)   load_hold = 1'b1;
          else if (word_acc) load_word = 1'b1;
          else               state_d   = IDLE;
        end else if (word_acc) begin
          to_hold = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shifter_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      if (last_xfer)     cnt_q <= '0;
      else if (bit_xfer) cnt_q <= cnt_q + 1'b1;

      if (load_word) begin
        shifter_q <= parallel_data;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
        par_q     <= ^parallel_data;
`endif
      end else if (load_hold) begin
        shifter_q <= hold_q;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
        par_q     <= ^hold_q;
`endif
      end else if (bit_xfer) begin
        if (msb_first) shifter_q <= {shifter_q[width-2:0], 1'b0};
        else           shifter_q <= {1'b0, shifter_q[width-1:1]};
      end

      if (to_hold) begin
        hold_q      <= parallel_data;
        hold_full_q <= 1'b1;
      end else if (load_hold) begin
        hold_full_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial
//   Scoreboard bench for parallel_to_serial. Accepted words are expanded
//   into expected (last, bit) pairs by a frame model; a monitor pops and
//   compares on every serial transfer and reassembles whole words.
module tb_parallel_to_serial;

  localparam int unsigned W   = 8;
  localparam bit          MSB = 1'b0;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  localparam bit          PAR = 1'b1;
`else
  localparam bit          PAR = 1'b0;
`endif
  localparam int unsigned FL  = W + (PAR ? 1 : 0);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         parallel_valid = 1'b0;
  logic         parallel_ready;
  logic [W-1:0] parallel_data = '0;
  logic         serial_valid;
  logic         serial_ready = 1'b1;
  logic         serial_data;
  logic         serial_last;

  int total = 0;
  int bad   = 0;

  logic [1:0]   exp_bits[$];   // {last, bit}
  logic [W-1:0] exp_words[$];
  logic [W-1:0] rx_word;
  int           rx_cnt = 0;
  logic         prev_hold = 1'b0;
  logic         prev_data, prev_last;

  int ready_mode = 0;          // 0: always 1, 1: 1,0,0,1 pattern, 2: random
  int pat_idx = 0;

  parallel_to_serial #(.width(W), .msb_first(MSB)) dut (
    .clk           (clk),
    .rst           (rst),
    .parallel_valid(parallel_valid),
    .parallel_ready(parallel_ready),
    .parallel_data (parallel_data),
    .serial_valid  (serial_valid),
    .serial_ready  (serial_ready),
    .serial_data   (serial_data),
    .serial_last   (serial_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit k (1-based) of the frame for word w, as {last, bit}.
  function automatic logic [1:0] frame_bit(input logic [W-1:0] w, input int k);
    logic b;
    if (k <= W) b = MSB ? w[W-k] : w[k-1];
    else        b = ^w;
    return {(k == FL), b};
  endfunction

  function automatic void push_word(input logic [W-1:0] w);
    for (int k = 1; k <= FL; k++) exp_bits.push_back(frame_bit(w, k));
    exp_words.push_back(w);
  endfunction

  // Downstream ready generator
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        serial_ready = (pat_idx == 0 || pat_idx == 3);
        pat_idx = (pat_idx + 1) % 4;
      end
      2:       serial_ready = ($urandom_range(0, 3) != 0);
      default: serial_ready = 1'b1;
    endcase
  end

  // Accept sampler: the handshake seen here completes on the next posedge.
  always @(negedge clk) begin
    if (rst && parallel_valid && parallel_ready) push_word(parallel_data);
  end

  // Output monitor
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && serial_valid) begin
        chk("stall_data_stable", serial_data, prev_data);
        chk("stall_last_stable", serial_last, prev_last);
      end
      if (serial_valid) begin
        if (exp_bits.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_bit: got valid bit %0b expected no bit at %0t", serial_data, $time);
        end else begin
          e = exp_bits[0];
          chk("serial_data", serial_data, e[0]);
          chk("serial_last", serial_last, e[1]);
          if (serial_ready) begin
            void'(exp_bits.pop_front());
            if (rx_cnt < W) begin
              if (MSB) rx_word[W-1-rx_cnt] = serial_data;
              else     rx_word[rx_cnt]     = serial_data;
            end
            rx_cnt++;
            if (serial_last) begin
              if (exp_words.size() == 0) begin
                total++; bad++;
                $display("FAIL rx_word: got %0h expected none", rx_word);
              end else begin
                chk("rx_word", rx_word, exp_words.pop_front());
              end
              rx_cnt = 0;
            end
          end
        end
      end else begin
        chk("idle_last_low", serial_last, 1'b0);
        chk("idle_ready_high", parallel_ready, 1'b1);
      end
      prev_hold = serial_valid && !serial_ready;
      prev_data = serial_data;
      prev_last = serial_last;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [W-1:0] w);
    bit ok = 1'b0;
    parallel_valid = 1'b1;
    parallel_data  = w;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (parallel_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: got no ready expected ready within 1000 cycles");
    end
    @(posedge clk); #1;
    parallel_valid = 1'b0;
    parallel_data  = W'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_bits.size() == 0 && !serial_valid) break;
    end
    chk("drain_bits_left", exp_bits.size(), 0);
    chk("drain_words_left", exp_words.size(), 0);
    @(posedge clk); #1;
  endtask

  // One word with serial_ready=1: exact per-cycle latency and framing.
  task automatic single_word(input logic [W-1:0] w);
    logic [1:0] e;
    send_word(w);
    for (int k = 1; k <= FL; k++) begin
      e = frame_bit(w, k);
      @(negedge clk);
      chk("single_valid", serial_valid, 1'b1);
      chk("single_data", serial_data, e[0]);
      chk("single_last", serial_last, e[1]);
    end
    @(negedge clk);
    chk("single_end_valid", serial_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held with random inputs
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      parallel_valid = 1'($urandom);
      parallel_data  = W'($urandom);
      @(negedge clk);
      chk("rst_serial_valid", serial_valid, 1'b0);
      chk("rst_parallel_ready", parallel_ready, 1'b1);
      chk("rst_serial_data", serial_data, 1'b0);
      chk("rst_serial_last", serial_last, 1'b0);
    end
    @(posedge clk); #1;
    parallel_valid = 1'b0;
    rst = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", serial_valid, 1'b0);
    end
    @(posedge clk); #1;

    single_word(8'hA5);
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
    single_word(8'h07);
`endif

    // Back-to-back with valid held high
    parallel_valid = 1'b1;
    parallel_data  = 8'h01;
    @(negedge clk);
    chk("b2b_ready_first", parallel_ready, 1'b1);
    @(posedge clk); #1;
    parallel_data = 8'h80;
    @(negedge clk);
    chk("b2b_ready_second", parallel_ready, 1'b1);
    chk("b2b_valid", serial_valid, 1'b1);
    @(posedge clk); #1;
    parallel_valid = 1'b0;
    for (int i = 2; i <= 2 * FL; i++) begin
      @(negedge clk);
      chk("b2b_contiguous", serial_valid, 1'b1);
      if (i == 2) chk("b2b_hold_full_ready", parallel_ready, 1'b0);
    end
    @(negedge clk);
    chk("b2b_end_valid", serial_valid, 1'b0);
    @(posedge clk); #1;
    drain();

    // Backpressure pattern 1,0,0,1
    ready_mode = 1;
    send_word(8'h3C);
    send_word(8'hC9);
    drain();

    // Random traffic with random backpressure and gaps
    ready_mode = 2;
    for (int n = 0; n < 100; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_word(W'($urandom));
    end
    drain();

    // Reset mid-frame after 3 bits of 8'hFF
    ready_mode = 0;
    send_word(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_valid", serial_valid, 1'b0);
    chk("midrst_ready", parallel_ready, 1'b1);
    exp_bits.delete();
    exp_words.delete();
    rx_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_no_resume", serial_valid, 1'b0);
    @(posedge clk); #1;
    single_word(8'h00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
